// File: rtl/mips_multicycle_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: opcodes, FSM states,
// datapath mux codes and the control-word payload driven to the datapath.
package mips_multicycle_ctrl_pkg;

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_ADDI = 6'h08;

  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_EXEC      = 4'd6,
    S_R_WB      = 4'd7,
    S_BRANCH    = 4'd8,
    S_JUMP      = 4'd9,
    S_ADDI_EXEC = 4'd10,
    S_ADDI_WB   = 4'd11,
    S_HALT      = 4'd12
  } state_t;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       halted;
  } ctrl_t;

endpackage

// File: rtl/mips_multicycle_ctrl_decode.sv
// Combinational control-word decode: current state (plus mem_ready for the
// fetch-stage IR/PC loads) to datapath mux selects and enables.
module mips_multicycle_ctrl_decode
  import mips_multicycle_ctrl_pkg::*;
(
  input  state_t i_state,
  input  logic   i_mem_ready,
  output ctrl_t  o_ctrl
);

  always_comb begin
    o_ctrl = '0;
    case (i_state)
      S_FETCH: begin
        o_ctrl.mem_read  = 1'b1;
        o_ctrl.alu_src_b = SRCB_FOUR;
        o_ctrl.ir_write  = i_mem_ready;
        o_ctrl.pc_write  = i_mem_ready;
      end
      // Branch target is precomputed into ALUOut while the opcode resolves
      S_DECODE: o_ctrl.alu_src_b = SRCB_IMM_SH;
      S_MEM_ADDR: begin
        o_ctrl.alu_src_a = 1'b1;
        o_ctrl.alu_src_b = SRCB_IMM;
      end
      S_MEM_READ: begin
        o_ctrl.mem_read = 1'b1;
        o_ctrl.iord     = 1'b1;
      end
      S_MEM_WB: begin
        o_ctrl.reg_write  = 1'b1;
        o_ctrl.mem_to_reg = 1'b1;
      end
      S_MEM_WRITE: begin
        o_ctrl.mem_write = 1'b1;
        o_ctrl.iord      = 1'b1;
      end
      S_EXEC: begin
        o_ctrl.alu_src_a = 1'b1;
        o_ctrl.alu_op    = ALUOP_FUNCT;
      end
      S_R_WB: begin
        o_ctrl.reg_write = 1'b1;
        o_ctrl.reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        o_ctrl.alu_src_a     = 1'b1;
        o_ctrl.alu_op        = ALUOP_SUB;
        o_ctrl.pc_write_cond = 1'b1;
        o_ctrl.pc_source     = PCSRC_ALUOUT;
      end
      S_JUMP: begin
        o_ctrl.pc_write  = 1'b1;
        o_ctrl.pc_source = PCSRC_JUMP;
      end
      S_ADDI_EXEC: begin
        o_ctrl.alu_src_a = 1'b1;
        o_ctrl.alu_src_b = SRCB_IMM;
      end
      S_ADDI_WB: o_ctrl.reg_write = 1'b1;
      S_HALT:    o_ctrl.halted    = 1'b1;
      default:   o_ctrl = '0;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Main control FSM for the multi-cycle MIPS datapath: state register,
// next-state sequencing, retired-instruction counter and reset-gated outputs.
module mips_multicycle_ctrl
  import mips_multicycle_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [5:0]       i_opcode,
  input  logic             i_alu_zero,
  input  logic             i_mem_ready,
  output logic             o_pc_write,
  output logic             o_pc_write_cond,
  output logic             o_iord,
  output logic             o_mem_read,
  output logic             o_mem_write,
  output logic             o_ir_write,
  output logic             o_mem_to_reg,
  output logic             o_reg_dst,
  output logic             o_reg_write,
  output logic             o_alu_src_a,
  output logic [1:0]       o_alu_src_b,
  output logic [1:0]       o_alu_op,
  output logic [1:0]       o_pc_source,
  output logic [3:0]       o_state,
  output logic             o_halted,
  output logic [CNT_W-1:0] o_retired
);

  state_t           r_state;
  logic [CNT_W-1:0] r_retired;
  ctrl_t            w_ctrl;
  ctrl_t            w_out;
  logic             w_unused;

  // The beq decision is made in the datapath via pc_write_cond & zero
  assign w_unused = i_alu_zero;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= S_FETCH;
      r_retired <= '0;
    end else begin
      case (r_state)
        S_FETCH: if (i_mem_ready) r_state <= S_DECODE;
        S_DECODE: begin
          case (i_opcode)
            OP_LW, OP_SW: r_state <= S_MEM_ADDR;
            OP_R:         r_state <= S_EXEC;
            OP_BEQ:       r_state <= S_BRANCH;
            OP_J:         r_state <= S_JUMP;
            OP_ADDI:      r_state <= S_ADDI_EXEC;
            default:      r_state <= S_HALT;
          endcase
        end
        S_MEM_ADDR: r_state <= (i_opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
        S_MEM_READ: if (i_mem_ready) r_state <= S_MEM_WB;
        S_MEM_WRITE: begin
          if (i_mem_ready) begin
            r_state   <= S_FETCH;
            r_retired <= r_retired + CNT_W'(1);
          end
        end
        S_MEM_WB, S_R_WB, S_BRANCH, S_JUMP, S_ADDI_WB: begin
          r_state   <= S_FETCH;
          r_retired <= r_retired + CNT_W'(1);
        end
        S_EXEC:      r_state <= S_R_WB;
        S_ADDI_EXEC: r_state <= S_ADDI_WB;
        S_HALT:      r_state <= S_HALT;
        default:     r_state <= S_HALT;
      endcase
    end
  end

  mips_multicycle_ctrl_decode u_decode (
    .i_state     (r_state),
    .i_mem_ready (i_mem_ready),
    .o_ctrl      (w_ctrl)
  );

  // Everything reads zero while reset is held, so no enable leaks into the reset cycle
  assign w_out = i_rst ? '0 : w_ctrl;

  assign o_pc_write      = w_out.pc_write;
  assign o_pc_write_cond = w_out.pc_write_cond;
  assign o_iord          = w_out.iord;
  assign o_mem_read      = w_out.mem_read;
  assign o_mem_write     = w_out.mem_write;
  assign o_ir_write      = w_out.ir_write;
  assign o_mem_to_reg    = w_out.mem_to_reg;
  assign o_reg_dst       = w_out.reg_dst;
  assign o_reg_write     = w_out.reg_write;
  assign o_alu_src_a     = w_out.alu_src_a;
  assign o_alu_src_b     = w_out.alu_src_b;
  assign o_alu_op        = w_out.alu_op;
  assign o_pc_source     = w_out.pc_source;
  assign o_halted        = w_out.halted;
  assign o_state         = i_rst ? 4'd0 : 4'(r_state);
  assign o_retired       = i_rst ? '0 : r_retired;

endmodule
